branch_resolve_ctrl: RTL and testbench

Branch resolution and prediction controller for the pipelined RV32I core. It holds a table of 2-bit saturating counters that supplies the fetch stage with a taken/not-taken prediction. It consumes the comparator's `br_en` for the branch in EX, updates the table, and on a misprediction sequences a one-cycle PC redirect plus a multi-cycle flush of younger stages. It sits between the EX-stage comparator, the fetch PC mux and the pipeline-register flush controls.

---
 rtl/branch_resolve_ctrl.sv | 131 +++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_ctrl.sv
// Branch resolve/predict controller: 2-bit BHT, mispredict redirect and flush.
// Optional perf counters under BRANCH_PERF_CNT_EN.
module branch_resolve_ctrl #(
  parameter int BHT_IDX_W    = 6,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        if_pred_taken,
  input  logic        ex_valid,
  input  logic [6:0]  ex_opcode,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        ex_br_en,
  input  logic        ex_pred_taken,
  input  logic        stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        busy,
  output logic [15:0] perf_branches,
  output logic [15:0] perf_mispredicts
);

  localparam int          ENTRIES = 2 ** BHT_IDX_W;
  localparam logic [6:0]  OP_BR   = 7'b1100011;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [1:0] bht [ENTRIES];
  logic [1:0] ctr_cur, ctr_nxt;
  logic [BHT_IDX_W-1:0] if_idx, ex_idx;
  logic resolve, mispred;
  logic unused_pc_bits;

  assign if_idx  = if_pc[BHT_IDX_W+1:2];
  assign ex_idx  = ex_pc[BHT_IDX_W+1:2];
  assign unused_pc_bits = ^{if_pc[31:BHT_IDX_W+2], if_pc[1:0]};

  assign resolve = ex_valid && (ex_opcode == OP_BR) && !stall
                   && (state == RUN);
  assign mispred = resolve && (ex_br_en != ex_pred_taken);

  assign if_pred_taken = bht[if_idx][1];
  assign ctr_cur       = bht[ex_idx];
  assign flush         = (state == FLUSH);
  assign busy          = (state == FLUSH);

  // Saturating counter step for the resolving branch
  always_comb begin
    ctr_nxt = ctr_cur;
    if (ex_br_en) begin
      if (ctr_cur != 2'b11) ctr_nxt = ctr_cur + 2'b01;
    end else begin
      if (ctr_cur != 2'b00) ctr_nxt = ctr_cur - 2'b01;
    end
  end

  // Prediction table write; lookup in the same cycle sees the old value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) bht[i] <= 2'b01;
    end else if (resolve) begin
      bht[ex_idx] <= ctr_nxt;
    end
  end

  // State and flush counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: enter FLUSH on mispredict, count down ignoring stall
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      RUN: begin
        if (mispred) begin
          state_nxt = FLUSH;
          cnt_nxt   = 4'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (cnt == 4'd0) state_nxt = RUN;
        else cnt_nxt = cnt - 4'd1;
      end
      default: state_nxt = RUN;
    endcase
  end

  // One-cycle redirect strobe; PC holds its last corrected value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
    end else begin
      redirect_valid <= mispred;
      if (mispred)
        redirect_pc <= ex_br_en ? ex_target : ex_pc + 32'd4;
    end
  end

`ifdef BRANCH_PERF_CNT_EN
  // Saturating resolve and mispredict counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_branches    <= 16'h0000;
      perf_mispredicts <= 16'h0000;
    end else begin
      if (resolve && perf_branches != 16'hFFFF)
        perf_branches <= perf_branches + 16'd1;
      if (mispred && perf_mispredicts != 16'hFFFF)
        perf_mispredicts <= perf_mispredicts + 16'd1;
    end
  end
`else
  assign perf_branches    = 16'h0000;
  assign perf_mispredicts = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Scoreboard bench for branch_resolve_ctrl with a table-level reference model.
// Honours BRANCH_PERF_CNT_EN when checking perf outputs.
module tb_branch_resolve_ctrl;

  localparam int FC = 2;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_J  = 7'b1101111;

  logic clk = 0;
  logic rst = 1;
  logic [31:0] if_pc = 0;
  logic ex_valid = 0;
  logic [6:0] ex_opcode = 0;
  logic [31:0] ex_pc = 0, ex_target = 0;
  logic ex_br_en = 0, ex_pred_taken = 0, stall = 0;

  logic pred, rv, fl, bsy;
  logic [31:0] rpc;
  logic [15:0] pb, pm;
  logic pred2, rv2, fl2, bsy2;
  logic [31:0] rpc2;
  logic [15:0] pb2, pm2;

  always #5 clk = ~clk;

  branch_resolve_ctrl #(.BHT_IDX_W(6), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(pred),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_pc(ex_pc),
    .ex_target(ex_target), .ex_br_en(ex_br_en),
    .ex_pred_taken(ex_pred_taken), .stall(stall),
    .redirect_valid(rv), .redirect_pc(rpc), .flush(fl), .busy(bsy),
    .perf_branches(pb), .perf_mispredicts(pm));

  branch_resolve_ctrl #(.BHT_IDX_W(6), .FLUSH_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(pred2),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_pc(ex_pc),
    .ex_target(ex_target), .ex_br_en(ex_br_en),
    .ex_pred_taken(ex_pred_taken), .stall(stall),
    .redirect_valid(rv2), .redirect_pc(rpc2), .flush(fl2), .busy(bsy2),
    .perf_branches(pb2), .perf_mispredicts(pm2));

  typedef struct packed {
    logic pred;
    logic rv;
    logic fl;
    logic [31:0] rpc;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_pass = 0;
  int run4 = 0;

  int m_ctr [64];
  int m_left, m_br, m_mp;
  logic m_rv;
  logic [31:0] m_rpc;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 64; i++) m_ctr[i] = 1;
    m_left = 0; m_rv = 0; m_rpc = 0; m_br = 0; m_mp = 0;
  endfunction

  function automatic int ix(input logic [31:0] a);
    return int'(a[7:2]);
  endfunction

  function automatic logic m_pred(input logic [31:0] a);
    return m_ctr[ix(a)] >= 2;
  endfunction

  // Drive one cycle; push this cycle's expected outputs, then step the model
  task automatic drive(input logic v, input logic [6:0] op,
                       input logic [31:0] pc, input logic [31:0] tgt,
                       input logic br, input logic pt, input logic st,
                       input logic [31:0] ipc);
    exp_t e;
    @(posedge clk); #1;
    ex_valid = v; ex_opcode = op; ex_pc = pc; ex_target = tgt;
    ex_br_en = br; ex_pred_taken = pt; stall = st; if_pc = ipc;
    e.pred = m_pred(ipc);
    e.rv = m_rv;
    e.fl = (m_left > 0);
    e.rpc = m_rpc;
    q.push_back(e);
    if (m_left > 0) begin
      m_left--;
      m_rv = 0;
    end else if (v && op == OP_BR && !st) begin
      if (br) m_ctr[ix(pc)] = (m_ctr[ix(pc)] == 3) ? 3 : m_ctr[ix(pc)] + 1;
      else    m_ctr[ix(pc)] = (m_ctr[ix(pc)] == 0) ? 0 : m_ctr[ix(pc)] - 1;
      if (m_br < 65535) m_br++;
      if (br != pt) begin
        m_rv = 1;
        m_rpc = br ? tgt : pc + 32'd4;
        m_left = FC;
        if (m_mp < 65535) m_mp++;
      end else begin
        m_rv = 0;
      end
    end else begin
      m_rv = 0;
    end
  endtask

  task automatic idle(input logic [31:0] ipc);
    drive(0, 7'd0, 0, 0, 0, 0, 0, ipc);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1;
    #1;
    chk("rst_flush", 32'(fl), 0);
    chk("rst_busy", 32'(bsy), 0);
    chk("rst_rv", 32'(rv), 0);
    chk("rst_rpc", rpc, 0);
    m_reset();
    run4 = 0;
    @(negedge clk); #1;
    rst = 0;
  endtask

  // Monitor: compare DUT outputs against the queued expectation each cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pred", 32'(pred), 32'(e.pred));
        chk("redirect_valid", 32'(rv), 32'(e.rv));
        chk("redirect_pc", rpc, e.rpc);
        chk("flush", 32'(fl), 32'(e.fl));
        chk("busy", 32'(bsy), 32'(e.fl));
      end
      if (fl2) run4++;
      else if (run4 > 0) begin
        chk("flush4_len", 32'(run4), 4);
        run4 = 0;
      end
    end
  end

  initial begin
    logic [31:0] pc, ipc;
    logic br, pt, st;
    logic [6:0] op;
    m_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("init_pb", 32'(pb), 0);
    chk("init_pm", 32'(pm), 0);
    chk("init_rpc", rpc, 0);
    rst = 0;

    idle(32'h40);
    drive(1, OP_BR, 32'h40, 32'h80, 1, 0, 0, 32'h40);
    repeat (3) idle(32'h40);

    drive(1, OP_BR, 32'h100, 32'h200, 0, 1, 0, 32'h100);
    repeat (3) idle(32'h100);
    for (int i = 0; i < 5; i++)
      drive(1, OP_BR, 32'h100, 32'h200, 0, m_pred(32'h100), 0, 32'h100);
    for (int i = 0; i < 5; i++)
      drive(1, OP_BR, 32'h180, 32'h0, 1, m_pred(32'h180), 0, 32'h180);
    idle(32'h180);

    drive(1, OP_R, 32'h40, 32'h0, 0, 1, 0, 32'h40);
    drive(1, OP_J, 32'h40, 32'h0, 0, 1, 0, 32'h40);
    drive(1, OP_BR, 32'h44, 32'h300, 1, 0, 1, 32'h44);
    drive(1, OP_BR, 32'h44, 32'h300, 1, 0, 1, 32'h44);
    drive(1, OP_BR, 32'h44, 32'h300, 1, 0, 0, 32'h44);
    drive(1, OP_BR, 32'h48, 32'h400, 1, 0, 0, 32'h48);
    repeat (4) idle(32'h48);

    drive(1, OP_BR, 32'hFFFFFFFC, 32'h10, 0, 1, 0, 32'hFFFFFFFC);
    repeat (5) idle(32'h0);

    drive(1, OP_BR, 32'h50, 32'h500, 1, 0, 0, 32'h50);
    idle(32'h50);
    do_reset();
    idle(32'h40);
    idle(32'h50);

    for (int n = 0; n < 1500; n++) begin
      pc = 32'($urandom_range(0, 63)) << 2;
      if ($urandom_range(0, 15) == 0) pc = 32'hFFFFFFFC;
      ipc = $urandom_range(0, 1) ? pc : 32'($urandom_range(0, 255)) << 2;
      op = ($urandom_range(0, 9) < 7) ? OP_BR
         : ($urandom_range(0, 1) ? OP_R : OP_J);
      br = 1'($urandom_range(0, 1));
      pt = ($urandom_range(0, 9) < 7) ? m_pred(pc) : 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 4) == 0);
      drive(1'($urandom_range(0, 7) != 0), op, pc, $urandom, br, pt, st, ipc);
    end
    repeat (6) idle(32'h0);

    do_reset();
    drive(1, OP_BR, 32'h60, 32'h600, 0, 0, 0, 32'h60);
    drive(1, OP_BR, 32'h64, 32'h640, 1, 0, 0, 32'h64);
    repeat (FC) idle(32'h64);
    drive(1, OP_BR, 32'h68, 32'h680, 0, 0, 0, 32'h68);
    idle(32'h60);
    @(negedge clk); #1;
`ifdef BRANCH_PERF_CNT_EN
    chk("perf_branches", 32'(pb), 32'(m_br));
    chk("perf_mispredicts", 32'(pm), 32'(m_mp));
`else
    chk("perf_branches", 32'(pb), 0);
    chk("perf_mispredicts", 32'(pm), 0);
`endif
    chk("queue_drained", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
